button_event_classifier: RTL and testbench

BUTTON_EVENT_CLASSIFIER -- requirements
Module: button_event_classifier

---
 rtl/button_event_classifier.sv | 137 +++++++++++++
 tb/tb_button_event_classifier.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/button_event_classifier.sv
// rtl/button_event_classifier.sv - classifies a debounced button level into short, long and double-click events
module button_event_classifier #(
  parameter int LONG_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 15_000_000,
  parameter int CNT_W       = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clean_in,
  output logic       pressed,
  output logic       short_press,
  output logic       long_press,
  output logic       double_click,
  output logic [7:0] event_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_HOLD,
    S_GAP,
    S_PRESS2
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_MAX   = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_prev;
  logic             r_short;
  logic             r_long;
  logic             r_double;
  logic [7:0]       r_event_count;
  logic             w_short;
  logic             w_long;
  logic             w_double;
  logic             w_any;
  logic             w_rise;
  logic             w_fall;

  assign w_rise = clean_in & ~r_prev;
  assign w_fall = ~clean_in & r_prev;
  assign w_any  = w_short | w_long | w_double;

  // r_cnt holds the number of consecutive samples already seen at the current level
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_short      = 1'b0;
    w_long       = 1'b0;
    w_double     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_next_state = S_PRESS1;
          w_cnt_next   = CNT_ONE;
        end
      end
      S_PRESS1: begin
        if (w_fall) begin
          w_next_state = S_GAP;
          w_cnt_next   = CNT_ONE;
        end else if (clean_in) begin
          if (r_cnt == LONG_LAST) begin
            w_long       = 1'b1;
            w_next_state = S_HOLD;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + CNT_ONE;
          end
        end
      end
      S_HOLD: begin
        if (w_fall) begin
          w_next_state = S_IDLE;
        end
      end
      S_GAP: begin
        if (w_rise && (r_cnt < GAP_MAX)) begin
          w_double     = 1'b1;
          w_next_state = S_PRESS2;
          w_cnt_next   = '0;
        end else if (!clean_in) begin
          if (r_cnt == GAP_LAST) begin
            w_short      = 1'b1;
            w_next_state = S_IDLE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + CNT_ONE;
          end
        end
      end
      S_PRESS2: begin
        if (w_fall) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Pulses and the event counter update on the same edge so they are visible together
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_prev        <= 1'b0;
      r_short       <= 1'b0;
      r_long        <= 1'b0;
      r_double      <= 1'b0;
      r_event_count <= 8'd0;
    end else begin
      r_state       <= w_next_state;
      r_cnt         <= w_cnt_next;
      r_prev        <= clean_in;
      r_short       <= w_short;
      r_long        <= w_long;
      r_double      <= w_double;
      r_event_count <= r_event_count + {7'd0, w_any};
    end
  end

  assign pressed      = r_prev;
  assign short_press  = r_short;
  assign long_press   = r_long;
  assign double_click = r_double;
  assign event_count  = r_event_count;

endmodule

// File: tb/tb_button_event_classifier.sv
// tb/tb_button_event_classifier.sv - directed self-checking bench for button_event_classifier
module tb_button_event_classifier;

  localparam logic [2:0] NONE = 3'b000;
  localparam logic [2:0] SHORT = 3'b100;
  localparam logic [2:0] LONG = 3'b010;
  localparam logic [2:0] DBL = 3'b001;

  logic       clk;
  logic       reset;
  logic       clean_in;
  logic       pressed;
  logic       short_press;
  logic       long_press;
  logic       double_click;
  logic [7:0] event_count;

  int n_checks;
  int n_err;

  button_event_classifier #(
    .LONG_CYCLES(8),
    .GAP_CYCLES (5),
    .CNT_W      (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clean_in    (clean_in),
    .pressed     (pressed),
    .short_press (short_press),
    .long_press  (long_press),
    .double_click(double_click),
    .event_count (event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic lvl);
    @(negedge clk);
    reset    = 1'b0;
    clean_in = lvl;
    @(posedge clk);
    #1;
  endtask

  // n samples at one level; sample number hit (1-based, 0 for none) must show the pulse kind
  task automatic seg(input logic lvl, input int n, input int hit, input logic [2:0] kind, input string tag);
    for (int i = 1; i <= n; i++) begin
      step(lvl);
      chk($sformatf("%s_pulse%0d", tag, i), {29'd0, short_press, long_press, double_click},
          {29'd0, (i == hit) ? kind : NONE});
      chk($sformatf("%s_pressed%0d", tag, i), {31'd0, pressed}, {31'd0, lvl});
    end
  endtask

  task automatic do_reset(input int n, input logic toggle, input logic lvl, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset    = 1'b1;
      clean_in = toggle ? ~clean_in : lvl;
      @(posedge clk);
      #1;
      chk($sformatf("%s_outs%0d", tag, i), {28'd0, pressed, short_press, long_press, double_click}, 32'd0);
      chk($sformatf("%s_count%0d", tag, i), {24'd0, event_count}, 32'd0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    reset    = 1'b1;
    clean_in = 1'b0;

    do_reset(6, 1'b1, 1'b0, "rst_toggle");

    seg(1'b1, 3, 0, NONE, "short_hi");
    seg(1'b0, 10, 5, SHORT, "short_lo");
    chk("short_count", {24'd0, event_count}, 32'd1);

    do_reset(2, 1'b0, 1'b0, "rst_b");
    seg(1'b1, 12, 8, LONG, "long_hi");
    seg(1'b0, 10, 0, NONE, "long_lo");
    chk("long_count", {24'd0, event_count}, 32'd1);

    do_reset(2, 1'b0, 1'b0, "rst_c");
    seg(1'b1, 2, 0, NONE, "dbl_hi1");
    seg(1'b0, 3, 0, NONE, "dbl_lo1");
    seg(1'b1, 2, 1, DBL, "dbl_hi2");
    seg(1'b0, 10, 0, NONE, "dbl_lo2");
    chk("dbl_count", {24'd0, event_count}, 32'd1);

    do_reset(2, 1'b0, 1'b0, "rst_d");
    seg(1'b1, 2, 0, NONE, "gap5_hi1");
    seg(1'b0, 5, 5, SHORT, "gap5_lo1");
    seg(1'b1, 2, 0, NONE, "gap5_hi2");
    seg(1'b0, 10, 5, SHORT, "gap5_lo2");
    chk("gap5_count", {24'd0, event_count}, 32'd2);

    do_reset(2, 1'b0, 1'b0, "rst_e");
    seg(1'b1, 2, 0, NONE, "gap4_hi1");
    seg(1'b0, 4, 0, NONE, "gap4_lo1");
    seg(1'b1, 2, 1, DBL, "gap4_hi2");
    seg(1'b0, 10, 0, NONE, "gap4_lo2");
    chk("gap4_count", {24'd0, event_count}, 32'd1);

    // Button held into reset and released before reset ends: nothing is reported
    do_reset(2, 1'b0, 1'b0, "rst_f");
    seg(1'b1, 4, 0, NONE, "midrst_hi");
    do_reset(2, 1'b0, 1'b1, "midrst_held");
    do_reset(1, 1'b0, 1'b0, "midrst_rel");
    seg(1'b0, 10, 0, NONE, "midrst_lo");
    chk("midrst_count", {24'd0, event_count}, 32'd0);

    // Button still held after reset ends: counting restarts from a fresh press
    seg(1'b1, 4, 0, NONE, "fresh_hi0");
    do_reset(2, 1'b0, 1'b1, "fresh_held");
    seg(1'b1, 8, 8, LONG, "fresh_hi");
    seg(1'b0, 10, 0, NONE, "fresh_lo");
    chk("fresh_count", {24'd0, event_count}, 32'd1);

    do_reset(2, 1'b0, 1'b0, "rst_g");
    for (int k = 0; k < 255; k++) begin
      seg(1'b1, 1, 0, NONE, "wrap_hi");
      seg(1'b0, 5, 5, SHORT, "wrap_lo");
    end
    chk("wrap_count255", {24'd0, event_count}, 32'd255);
    seg(1'b1, 1, 0, NONE, "wrap_last_hi");
    seg(1'b0, 5, 5, SHORT, "wrap_last_lo");
    chk("wrap_count0", {24'd0, event_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
